// File: rtl/alu_issue_stage.sv
// Issue stage between a command handshake and an external combinational ALU.
// Holds ALU operands, waits a settle delay, captures results and tracks signed overflow.
module alu_issue_stage #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_cout,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_out,
  output logic        res_cout,
  output logic        res_zero,
  output logic        res_overflow,
  input  logic        clr_sticky,
  output logic        sticky_ovf,
  output logic [15:0] res_count
);

  // state | meaning
  // IDLE  | ready for a command
  // WAIT  | operands driven, counting down the ALU settle time
  // DONE  | results captured, waiting for res_ready
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  logic       capture;
  logic       set_sticky;

  assign capture    = (state == WAIT) && (cnt == 4'd1);
  // Only ADD/SUB overflow is meaningful as signed overflow.
  assign set_sticky = capture && alu_overflow && (alu_op[2:1] == 2'b00);

  // Gated by reset so the handshakes drop in the same cycle reset is raised.
  assign in_ready  = (state == IDLE) && !reset;
  assign res_valid = (state == DONE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      alu_a        <= 32'd0;
      alu_b        <= 32'd0;
      alu_op       <= 3'd0;
      res_out      <= 32'd0;
      res_cout     <= 1'b0;
      res_zero     <= 1'b0;
      res_overflow <= 1'b0;
      sticky_ovf   <= 1'b0;
      res_count    <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_a  <= in_a;
            alu_b  <= in_b;
            alu_op <= in_op;
            cnt    <= SETTLE;
            state  <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (capture) begin
            res_out      <= alu_out;
            res_cout     <= alu_cout;
            res_zero     <= alu_zero;
            res_overflow <= alu_overflow;
            state        <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_count <= res_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (set_sticky) begin
        sticky_ovf <= 1'b1;
      end else if (clr_sticky) begin
        sticky_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU plus reference arithmetic model,
// one instance at the default settle time and one at SETTLE_CYCLES=4.
module tb_alu_issue_stage;
  logic        clk, reset, reset_4, in_valid, in_valid_4, res_ready, clr_sticky, ovf_force;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_op;

  logic        in_ready, res_valid, res_cout, res_zero, res_overflow, sticky_ovf;
  logic [31:0] res_out, alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic [15:0] res_count;
  logic        alu_cout, alu_zero, alu_overflow;
  logic [34:0] alu_res;

  logic        in_ready_4, res_valid_4, res_cout_4, res_zero_4, res_overflow_4, sticky_ovf_4;
  logic [31:0] res_out_4, alu_a_4, alu_b_4, alu_out_4;
  logic [2:0]  alu_op_4;
  logic [15:0] res_count_4;
  logic        alu_cout_4, alu_zero_4, alu_overflow_4;
  logic [34:0] alu_res_4;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_count;
  logic        exp_sticky;

  // Reference ALU: {cout, zero, overflow, result}
  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0; v = 1'b0; s = 33'd0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                  v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {c, (r == 32'd0), v, r};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Bench ALU; ovf_force injects a spurious overflow on non-arithmetic ops.
  assign alu_res      = alu_f(alu_a, alu_b, alu_op);
  assign alu_out      = alu_res[31:0];
  assign alu_cout     = alu_res[34];
  assign alu_zero     = alu_res[33];
  assign alu_overflow = alu_res[32] | (ovf_force && (alu_op > 3'd1));
  assign alu_res_4      = alu_f(alu_a_4, alu_b_4, alu_op_4);
  assign alu_out_4      = alu_res_4[31:0];
  assign alu_cout_4     = alu_res_4[34];
  assign alu_zero_4     = alu_res_4[33];
  assign alu_overflow_4 = alu_res_4[32];

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_out(res_out), .res_cout(res_cout), .res_zero(res_zero), .res_overflow(res_overflow),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .res_count(res_count)
  );

  alu_issue_stage #(.SETTLE_CYCLES(4)) dut_4 (
    .clk(clk), .reset(reset_4), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a_4), .alu_b(alu_b_4), .alu_op(alu_op_4),
    .alu_out(alu_out_4), .alu_cout(alu_cout_4), .alu_zero(alu_zero_4), .alu_overflow(alu_overflow_4),
    .res_valid(res_valid_4), .res_ready(res_ready),
    .res_out(res_out_4), .res_cout(res_cout_4), .res_zero(res_zero_4), .res_overflow(res_overflow_4),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf_4), .res_count(res_count_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the SETTLE_CYCLES=1 instance; returns what was observed.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input int hold,
                        output logic [31:0] r, output logic c, output logic z, output logic v,
                        output logic st, output int lat);
    logic [34:0] ref_r;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1; res_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 32) begin tick(); lat++; end
    r = res_out; c = res_cout; z = res_zero; v = res_overflow; st = sticky_ovf;
    repeat (hold) tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    ref_r = alu_f(a, b, op);
    exp_count++;
    if (op < 3'd2 && ref_r[32]) exp_sticky = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset_4 = 1'b1;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    tick();
    total++; if ({res_out, res_cout, res_zero, res_overflow} !== 35'd0) begin bad++; $display("FAIL reset_res got=%h exp=0", res_out); end
    total++; if ({alu_a, alu_b, alu_op} !== 67'd0) begin bad++; $display("FAIL reset_alu got=%h/%h/%h exp=0", alu_a, alu_b, alu_op); end
    total++; if (sticky_ovf !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b exp=0", sticky_ovf); end
    total++; if (res_count !== 16'd0 || res_count_4 !== 16'd0) begin bad++; $display("FAIL reset_count got=%h/%h exp=0", res_count, res_count_4); end
    reset = 1'b0; reset_4 = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1 || in_ready_4 !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b/%b exp=1", in_ready, in_ready_4); end
    exp_count = 16'd0; exp_sticky = 1'b0;
  endtask

  task automatic test_add_basic();
    logic [31:0] r; logic c, z, v, st; int lat;
    do_txn(32'h000F_FFFF, 32'h0000_0001, 3'd0, 0, r, c, z, v, st, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d exp=1", lat); end
    total++; if (r !== 32'h0010_0000) begin bad++; $display("FAIL add_result got=%h exp=00100000", r); end
    total++; if ({c, z, v} !== 3'b000) begin bad++; $display("FAIL add_flags got=%b exp=000", {c, z, v}); end
    total++; if (res_count !== 16'd1) begin bad++; $display("FAIL add_count got=%0d exp=1", res_count); end
    total++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL add_idle got=%b%b exp=10", in_ready, res_valid); end
  endtask

  task automatic test_add_carry();
    logic [31:0] r; logic c, z, v, st; int lat;
    do_txn(32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 0, r, c, z, v, st, lat);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL carry_result got=%h exp=0", r); end
    total++; if ({c, z, v} !== 3'b110) begin bad++; $display("FAIL carry_flags got=%b exp=110", {c, z, v}); end
    total++; if (sticky_ovf !== 1'b0) begin bad++; $display("FAIL carry_sticky got=%b exp=0", sticky_ovf); end
  endtask

  task automatic test_overflow_sticky();
    logic [31:0] r; logic c, z, v, st; int lat;
    do_txn(32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 0, r, c, z, v, st, lat);
    total++; if (r !== 32'h8000_0000 || v !== 1'b1) begin bad++; $display("FAIL ovf_add got=%h v=%b exp=80000000 v=1", r, v); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL ovf_sticky_set got=%b exp=1", st); end
    do_txn(32'h0, 32'h1, 3'd2, 1, r, c, z, v, st, lat);
    total++; if (r !== 32'h1) begin bad++; $display("FAIL ovf_xor got=%h exp=1", r); end
    total++; if (sticky_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky_hold got=%b exp=1", sticky_ovf); end
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    total++; if (sticky_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", sticky_ovf); end
    ovf_force = 1'b1;
    do_txn(32'hFFFF_0000, 32'h0F0F_0F0F, 3'd4, 0, r, c, z, v, st, lat);
    ovf_force = 1'b0;
    total++; if (r !== 32'h0F0F_0000 || v !== 1'b1) begin bad++; $display("FAIL ovf_and got=%h v=%b exp=0f0f0000 v=1", r, v); end
    total++; if (st !== 1'b0) begin bad++; $display("FAIL ovf_logic_no_sticky got=%b exp=0", st); end
    clr_sticky = 1'b1;
    do_txn(32'h8000_0000, 32'h8000_0000, 3'd0, 0, r, c, z, v, st, lat);
    total++; if (st !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", st); end
    total++; if (sticky_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr_after got=%b exp=0", sticky_ovf); end
    clr_sticky = 1'b0;
    do_txn(32'h8000_0000, 32'h0000_0001, 3'd1, 0, r, c, z, v, st, lat);
    total++; if (r !== 32'h7FFF_FFFF || v !== 1'b1 || st !== 1'b1) begin bad++; $display("FAIL ovf_sub got=%h v=%b st=%b exp=7fffffff 1 1", r, v, st); end
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    exp_sticky = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] cnt0;
    int          lat;
    cnt0 = res_count;
    in_a = 32'h8000_0008; in_b = 32'h0000_0002; in_op = 3'd3; in_valid = 1'b1; res_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 32) begin tick(); lat++; end
    total++; if (lat !== 1) begin bad++; $display("FAIL bp_latency got=%0d exp=1", lat); end
    for (int i = 0; i < 5; i++) begin
      total++; if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_out !== 32'h1) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b r=%b out=%h exp 1 0 1", i, res_valid, in_ready, res_out); end
      in_valid = (i == 2); in_a = 32'h1234_5678; in_op = 3'd0;
      tick();
    end
    in_valid = 1'b0;
    total++; if (alu_a !== 32'h8000_0008 || alu_op !== 3'd3) begin bad++; $display("FAIL bp_ignored got=%h/%h exp=80000008/3", alu_a, alu_op); end
    total++; if (res_count !== cnt0) begin bad++; $display("FAIL bp_no_count got=%0d exp=%0d", res_count, cnt0); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    exp_count++;
    total++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b%b exp=10", in_ready, res_valid); end
    total++; if (res_count !== cnt0 + 16'd1) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", res_count, cnt0 + 16'd1); end
  endtask

  task automatic test_back_to_back();
    logic [34:0] ra, rb;
    ra = alu_f(32'h0000_0005, 32'h0000_0003, 3'd1);
    rb = alu_f(32'hA5A5_0000, 32'h00FF_00FF, 3'd7);
    in_a = 32'h0000_0005; in_b = 32'h0000_0003; in_op = 3'd1; in_valid = 1'b1; res_ready = 1'b1;
    tick(); tick();
    total++; if (res_valid !== 1'b1 || res_out !== ra[31:0]) begin bad++; $display("FAIL b2b_first got=%b %h exp=1 %h", res_valid, res_out, ra[31:0]); end
    in_a = 32'hA5A5_0000; in_b = 32'h00FF_00FF; in_op = 3'd7;
    tick();
    total++; if (in_ready !== 1'b1 || alu_a !== 32'h0000_0005) begin bad++; $display("FAIL b2b_no_early got=%b %h exp=1 5", in_ready, alu_a); end
    tick();
    in_valid = 1'b0;
    total++; if (alu_a !== 32'hA5A5_0000 || in_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%h %b exp=a5a50000 0", alu_a, in_ready); end
    tick();
    total++; if (res_out !== rb[31:0]) begin bad++; $display("FAIL b2b_second got=%h exp=%h", res_out, rb[31:0]); end
    tick();
    res_ready = 1'b0;
    exp_count += 16'd2;
    total++; if (res_count !== exp_count) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", res_count, exp_count); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r; logic [2:0] op; logic c, z, v, st; logic [34:0] ref_r; int lat, hold;
    for (int n = 0; n < 40; n++) begin
      a = pick(); b = pick(); op = 3'($urandom_range(0, 7)); hold = $urandom_range(0, 3);
      ovf_force = 1'($urandom_range(0, 1));
      ref_r = alu_f(a, b, op);
      do_txn(a, b, op, hold, r, c, z, v, st, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL rnd_latency n=%0d got=%0d exp=1", n, lat); end
      total++; if (r !== ref_r[31:0]) begin bad++; $display("FAIL rnd_result n=%0d op=%0d got=%h exp=%h", n, op, r, ref_r[31:0]); end
      total++; if ({c, z, v} !== {ref_r[34], ref_r[33], ref_r[32] | (ovf_force && op > 3'd1)}) begin
        bad++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, {c, z, v}, {ref_r[34], ref_r[33], ref_r[32] | (ovf_force && op > 3'd1)}); end
      total++; if (st !== exp_sticky) begin bad++; $display("FAIL rnd_sticky n=%0d got=%b exp=%b", n, st, exp_sticky); end
      total++; if (res_count !== exp_count) begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, res_count, exp_count); end
      total++; if ({alu_a, alu_b, alu_op} !== {a, b, op}) begin bad++; $display("FAIL rnd_alu_hold n=%0d got=%h exp=%h", n, alu_a, a); end
    end
    ovf_force = 1'b0;
  endtask

  task automatic test_settle4();
    int   lat;
    logic seen;
    in_a = 32'h0000_1000; in_b = 32'h0000_0234; in_op = 3'd0; in_valid_4 = 1'b1; res_ready = 1'b1;
    tick();
    in_valid_4 = 1'b0;
    lat = 0;
    while (res_valid_4 !== 1'b1 && lat < 32) begin tick(); lat++; end
    total++; if (lat !== 4) begin bad++; $display("FAIL s4_latency got=%0d exp=4", lat); end
    total++; if (res_out_4 !== 32'h0000_1234) begin bad++; $display("FAIL s4_result got=%h exp=00001234", res_out_4); end
    tick();
    total++; if (res_count_4 !== 16'd1) begin bad++; $display("FAIL s4_count got=%0d exp=1", res_count_4); end
    in_valid_4 = 1'b1;
    tick();
    in_valid_4 = 1'b0;
    tick();
    reset_4 = 1'b1;
    total++; if (in_ready_4 !== 1'b0 || res_valid_4 !== 1'b0) begin bad++; $display("FAIL s4_in_reset got=%b%b exp=00", in_ready_4, res_valid_4); end
    tick();
    seen = 1'b0;
    reset_4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= res_valid_4;
      if (i == 0) begin
        total++; if (in_ready_4 !== 1'b1) begin bad++; $display("FAIL s4_ready_after_reset got=%b exp=1", in_ready_4); end
      end
    end
    res_ready = 1'b0;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL s4_abort_valid got=%b exp=0", seen); end
    total++; if (res_count_4 !== 16'd0 || res_out_4 !== 32'd0) begin bad++; $display("FAIL s4_abort_state got=%0d %h exp=0 0", res_count_4, res_out_4); end
  endtask

  initial begin
    reset = 1'b1; reset_4 = 1'b1; in_valid = 1'b0; in_valid_4 = 1'b0; res_ready = 1'b0;
    clr_sticky = 1'b0; ovf_force = 1'b0; in_a = 32'd0; in_b = 32'd0; in_op = 3'd0;
    exp_count = 16'd0; exp_sticky = 1'b0;
    tick();
    test_reset();
    test_add_basic();
    test_add_carry();
    test_overflow_sticky();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_settle4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning cycles between driving ALU operands and sampling ALU outputs; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  command present.
REQ-005 SHALL have port in_ready  output  1  stage can accept a command.
REQ-006 SHALL have ports in_a, in_b  input  32 each  operands.
REQ-007 SHALL have port in_op  input  3  ALU opcode: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR.
REQ-008 SHALL have ports alu_a, alu_b  output  32 each, and alu_op  output  3  registered drive to the ALU.
REQ-009 SHALL have ports alu_out  input  32, and alu_cout, alu_zero, alu_overflow  input  1 each  ALU results.
REQ-010 SHALL have ports res_valid  output  1, and res_ready  input  1  result handshake.
REQ-011 SHALL have ports res_out  output  32, and res_cout, res_zero, res_overflow  output  1 each  captured results.
REQ-012 SHALL have port clr_sticky  input  1  clears sticky_ovf.
REQ-013 SHALL have port sticky_ovf  output  1  sticky signed-overflow flag.
REQ-014 SHALL have port res_count  output  16  count of completed result handshakes.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready SHALL load alu_a/alu_b/alu_op from in_a/in_b/in_op, load settle counter with SETTLE_CYCLES, enter WAIT.
REQ-017 in_ready SHALL be 1 only in IDLE; in_valid in WAIT/DONE SHALL be ignored with no state change.
REQ-018 WAIT: if counter==1, SHALL capture alu_out/cout/zero/overflow into res_* and enter DONE; else decrement counter.
REQ-019 res_valid SHALL rise exactly SETTLE_CYCLES edges after the accepting edge.
REQ-020 DONE: res_valid=1; res_* SHALL hold stable until res_valid&res_ready, then enter IDLE (next accept no earlier than following edge).
REQ-021 alu_a/alu_b/alu_op SHALL hold stable from the accepting edge until the next accept.
REQ-022 On capture, sticky_ovf SHALL set if alu_overflow=1 and alu_op is 000 or 001; overflow on other ops SHALL not set it.
REQ-023 clr_sticky=1 SHALL clear sticky_ovf next edge; simultaneous set and clear: set wins.
REQ-024 res_count SHALL increment on each res_valid&res_ready edge, wrapping 0xFFFF->0x0000.
REQ-025 res_* SHALL pass ALU values unmodified; no sign/width transformation in this stage.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, in_ready=1 (after reset deasserts), res_valid=0, res_*=0, alu_a/alu_b=0, alu_op=000, counter=0, sticky_ovf=0, res_count=0.
REQ-027 reset SHALL override all handshakes in the same cycle; reset during WAIT or DONE SHALL discard the in-flight command with no res handshake and no res_count change.
REQ-028 in_ready and res_valid SHALL be 0 while reset is asserted.

Verification (bench connects the team's 32-bit ALU; SETTLE_CYCLES=1 unless noted)
REQ-029 ADD a=0x000FFFFF b=0x00000001, res_ready=1 -> res_valid 1 edge after accept, res_out=0x00100000, cout=0, zero=0, overflow=0, res_count=1.
REQ-030 ADD a=0xFFFFFFFF b=0x00000001 -> res_out=0x00000000, cout=1, zero=1, overflow=0, sticky_ovf=0.
REQ-031 ADD a=0x7FFFFFFF b=0x00000001 -> res_out=0x80000000, overflow=1, sticky_ovf=1 held through a following XOR 0x0^0x1 (res_out=0x00000001); clr_sticky pulse -> sticky_ovf=0.
REQ-032 SLT a=0x80000008 b=0x00000002, res_ready low 5 cycles -> res_out=0x00000001 stable, in_ready=0, second in_valid ignored; after res_ready=1, in_ready=1 next cycle, res_count increments by 1.
REQ-033 SETTLE_CYCLES=4: accept then reset asserted at 2nd WAIT edge -> res_valid never asserts, res_count unchanged, in_ready=1 one edge after reset deasserts.
